// File: rtl/b_format_decoder_if.sv
// b_format_decoder_if
//   Bundle between the decode front end and the B-form decode stage.
//   The front end presents one fetched instruction per cycle on the *_i
//   signals. The decoder returns a registered micro-op bundle on the *_o
//   signals.
//   Modports:
//     master - front end side: drives the instruction inputs and reads the micro-op.
//     slave  - decoder side: reads the instruction and drives the micro-op.
//   All vectors are MSB-first ([0:N-1]).
interface b_format_decoder_if #(
  parameter int addressWidth            = 64,
  parameter int instructionWidth        = 32,
  parameter int PidSize                 = 20,
  parameter int TidSize                 = 16,
  parameter int instructionCounterWidth = 64,
  parameter int instMinIdWidth          = 7,
  parameter int opcodeSize              = 12,
  parameter int PrimOpcodeSize          = 6,
  parameter int regSize                 = 5,
  parameter int immediateSize           = 14,
  parameter int funcUnitCodeSize        = 3,
  parameter int formatWidth             = 26
);
  localparam int bodyWidth = 2 * regSize + immediateSize + 4;

  // instruction side
  logic                                 enable_i;
  logic                                 stall_i;
  logic [0:formatWidth-1]               instFormat_i;
  logic [0:PrimOpcodeSize-1]            instructionOpcode_i;
  logic [0:instructionWidth-1]          instruction_i;
  logic [0:addressWidth-1]              instructionAddress_i;
  logic                                 is64Bit_i;
  logic [0:PidSize-1]                   instructionPid_i;
  logic [0:TidSize-1]                   instructionTid_i;
  logic [0:instructionCounterWidth-1]   instructionMajId_i;

  // micro-op side
  logic                                 enable_o;
  logic [0:opcodeSize-1]                opcode_o;
  logic [0:addressWidth-1]              instructionAddress_o;
  logic [0:funcUnitCodeSize-1]          functionalUnitType_o;
  logic [0:instructionCounterWidth-1]   instMajId_o;
  logic [0:instMinIdWidth-1]            instMinId_o;
  logic                                 is64Bit_o;
  logic [0:PidSize-1]                   instPid_o;
  logic [0:TidSize-1]                   instTid_o;
  logic [0:bodyWidth-1]                 instructionBody_o;

  modport master (
    output enable_i, stall_i, instFormat_i, instructionOpcode_i, instruction_i,
           instructionAddress_i, is64Bit_i, instructionPid_i, instructionTid_i,
           instructionMajId_i,
    input  enable_o, opcode_o, instructionAddress_o, functionalUnitType_o,
           instMajId_o, instMinId_o, is64Bit_o, instPid_o, instTid_o,
           instructionBody_o
  );

  modport slave (
    input  enable_i, stall_i, instFormat_i, instructionOpcode_i, instruction_i,
           instructionAddress_i, is64Bit_i, instructionPid_i, instructionTid_i,
           instructionMajId_i,
    output enable_o, opcode_o, instructionAddress_o, functionalUnitType_o,
           instMajId_o, instMinId_o, is64Bit_o, instPid_o, instTid_o,
           instructionBody_o
  );
endinterface

// File: rtl/b_format_decoder.sv
// b_format_decoder
//   Decode stage for PowerPC B-form conditional branches (primary opcode 16:
//   bc/bcl/bca/bcla). An accepted instruction produces a registered micro-op
//   one cycle later. A stall freezes every output. A non-matching or idle
//   cycle clears only enable_o, and the rest of the bundle keeps its last value.
//   Ports:
//     clock_i - rising-edge clock
//     reset_i - asynchronous, active-high reset; clears all outputs
//     bus     - b_format_decoder_if.slave (instruction in, micro-op out)
//   Optional feature macro: BFORMAT_DEBUG_EN enables simulation-only trace
//   messages for accepted instructions and for rejected B-format opcodes.
module b_format_decoder #(
  parameter int addressWidth            = 64,
  parameter int instructionWidth        = 32,
  parameter int PidSize                 = 20,
  parameter int TidSize                 = 16,
  parameter int instructionCounterWidth = 64,
  parameter int instMinIdWidth          = 7,
  parameter int opcodeSize              = 12,
  parameter int PrimOpcodeSize          = 6,
  parameter int regSize                 = 5,
  parameter int immediateSize           = 14,
  parameter int funcUnitCodeSize        = 3,
  parameter int BranchUnitID            = 6,
  parameter int B                       = 2,
  parameter int BDecoderInstance        = 0
) (
  input logic               clock_i,
  input logic               reset_i,
  b_format_decoder_if.slave bus
);
  localparam int formatWidth = 26;
  localparam int bodyWidth   = 2 * regSize + immediateSize + 4;
  localparam int boPos       = PrimOpcodeSize;
  localparam int biPos       = boPos + regSize;
  localparam int bdPos       = biPos + regSize;
  localparam int aaPos       = instructionWidth - 2;
  localparam int lkPos       = instructionWidth - 1;
  localparam int padWidth    = opcodeSize - PrimOpcodeSize - 2;

  localparam logic [0:PrimOpcodeSize-1] branchCondOpcode = PrimOpcodeSize'(32'd16);

  // instruction fields
  logic [0:regSize-1]       boField;
  logic [0:regSize-1]       biField;
  logic [0:immediateSize-1] bdField;
  logic                     aaBit;
  logic                     lkBit;
  logic                     isBFormat;
  logic                     acceptS;
  // the word's opcode bits duplicate instructionOpcode_i, which is what we decode on
  logic                     unusedOpcodeBits;

  assign boField          = bus.instruction_i[boPos +: regSize];
  assign biField          = bus.instruction_i[biPos +: regSize];
  assign bdField          = bus.instruction_i[bdPos +: immediateSize];
  assign aaBit            = bus.instruction_i[aaPos];
  assign lkBit            = bus.instruction_i[lkPos];
  assign unusedOpcodeBits = ^bus.instruction_i[0 +: PrimOpcodeSize];

  assign isBFormat = (bus.instFormat_i == formatWidth'(B));
  assign acceptS   = bus.enable_i && !bus.stall_i && isBFormat &&
                     (bus.instructionOpcode_i == branchCondOpcode);

  // output registers and their next values
  logic                               enableReg,  enableNext;
  logic [0:opcodeSize-1]              opcodeReg,  opcodeNext;
  logic [0:addressWidth-1]            addressReg, addressNext;
  logic [0:funcUnitCodeSize-1]        fuTypeReg,  fuTypeNext;
  logic [0:instructionCounterWidth-1] majIdReg,   majIdNext;
  logic [0:instMinIdWidth-1]          minIdReg,   minIdNext;
  logic                               is64BitReg, is64BitNext;
  logic [0:PidSize-1]                 pidReg,     pidNext;
  logic [0:TidSize-1]                 tidReg,     tidNext;
  logic [0:bodyWidth-1]               bodyReg,    bodyNext;

  // Next micro-op: load on accept, hold everything on stall, otherwise drop only the valid.
  always_comb begin
    enableNext  = enableReg;
    opcodeNext  = opcodeReg;
    addressNext = addressReg;
    fuTypeNext  = fuTypeReg;
    majIdNext   = majIdReg;
    minIdNext   = minIdReg;
    is64BitNext = is64BitReg;
    pidNext     = pidReg;
    tidNext     = tidReg;
    bodyNext    = bodyReg;
    if (bus.stall_i) begin
      enableNext = enableReg;
    end else if (acceptS) begin
      enableNext  = 1'b1;
      // AA/LK occupy the two low bits, so bc/bcl/bca/bcla become 0x400..0x403
      opcodeNext  = {bus.instructionOpcode_i, {padWidth{1'b0}}, aaBit, lkBit};
      addressNext = bus.instructionAddress_i;
      fuTypeNext  = funcUnitCodeSize'(BranchUnitID);
      majIdNext   = bus.instructionMajId_i;
      minIdNext   = {instMinIdWidth{1'b0}};
      is64BitNext = bus.is64Bit_i;
      pidNext     = bus.instructionPid_i;
      tidNext     = bus.instructionTid_i;
      bodyNext    = {boField, biField, bdField, aaBit, lkBit, 2'b00};
    end else begin
      enableNext = 1'b0;
    end
  end

  // Output register bank; reset clears the whole bundle asynchronously.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      enableReg  <= 1'b0;
      opcodeReg  <= {opcodeSize{1'b0}};
      addressReg <= {addressWidth{1'b0}};
      fuTypeReg  <= {funcUnitCodeSize{1'b0}};
      majIdReg   <= {instructionCounterWidth{1'b0}};
      minIdReg   <= {instMinIdWidth{1'b0}};
      is64BitReg <= 1'b0;
      pidReg     <= {PidSize{1'b0}};
      tidReg     <= {TidSize{1'b0}};
      bodyReg    <= {bodyWidth{1'b0}};
    end else begin
      enableReg  <= enableNext;
      opcodeReg  <= opcodeNext;
      addressReg <= addressNext;
      fuTypeReg  <= fuTypeNext;
      majIdReg   <= majIdNext;
      minIdReg   <= minIdNext;
      is64BitReg <= is64BitNext;
      pidReg     <= pidNext;
      tidReg     <= tidNext;
      bodyReg    <= bodyNext;
    end
  end

  assign bus.enable_o             = enableReg;
  assign bus.opcode_o             = opcodeReg;
  assign bus.instructionAddress_o = addressReg;
  assign bus.functionalUnitType_o = fuTypeReg;
  assign bus.instMajId_o          = majIdReg;
  assign bus.instMinId_o          = minIdReg;
  assign bus.is64Bit_o            = is64BitReg;
  assign bus.instPid_o            = pidReg;
  assign bus.instTid_o            = tidReg;
  assign bus.instructionBody_o    = bodyReg;

`ifdef BFORMAT_DEBUG_EN
  // Simulation trace of accepted branches and of B-format inputs with a foreign opcode.
  always @(posedge clock_i) begin
    if (!reset_i && acceptS) begin
      $display("BDecoder%0d: majId=%0h addr=%0h BO=%0h BI=%0h BD=%0h AA=%0b LK=%0b",
               BDecoderInstance, bus.instructionMajId_i, bus.instructionAddress_i,
               boField, biField, bdField, aaBit, lkBit);
    end else if (!reset_i && bus.enable_i && !bus.stall_i && isBFormat) begin
      $display("BDecoder%0d: warning, B-format input with opcode %0d ignored",
               BDecoderInstance, bus.instructionOpcode_i);
    end else begin
      // nothing to report this cycle
    end
  end
`else
  localparam int unusedDebugInstance = BDecoderInstance;
`endif

endmodule

// File: tb/tb_b_format_decoder.sv
// tb_b_format_decoder
//   Directed plus randomized stimulus for b_format_decoder. Expected outputs
//   come from a behavioural model of the branch decode rules, evaluated with
//   plain arithmetic on the instruction fields.
module tb_b_format_decoder;
  logic clock_i = 1'b0;
  logic reset_i = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  b_format_decoder_if busIf ();

  b_format_decoder dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .bus     (busIf)
  );

  always #5 clock_i = ~clock_i;

  // stimulus fields
  logic        en, st, m64;
  logic [25:0] fmt;
  int          opc, bo, bi, bd, aa, lk;
  logic [63:0] addr, maj;
  logic [19:0] pid;
  logic [15:0] tid;

  // model state
  logic        eEn;
  logic [63:0] eOp, eAddr, eFu, eMaj, eMin, e64, ePid, eTid, eBody;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    chk({tag, ".enable"}, 64'(busIf.enable_o), 64'(eEn));
    chk({tag, ".opcode"}, 64'(busIf.opcode_o), eOp);
    chk({tag, ".addr"},   64'(busIf.instructionAddress_o), eAddr);
    chk({tag, ".fu"},     64'(busIf.functionalUnitType_o), eFu);
    chk({tag, ".majId"},  64'(busIf.instMajId_o), eMaj);
    chk({tag, ".minId"},  64'(busIf.instMinId_o), eMin);
    chk({tag, ".is64"},   64'(busIf.is64Bit_o), e64);
    chk({tag, ".pid"},    64'(busIf.instPid_o), ePid);
    chk({tag, ".tid"},    64'(busIf.instTid_o), eTid);
    chk({tag, ".body"},   64'(busIf.instructionBody_o), eBody);
  endtask

  task automatic modelReset();
    eEn = 1'b0; eOp = '0; eAddr = '0; eFu = '0; eMaj = '0;
    eMin = '0; e64 = '0; ePid = '0; eTid = '0; eBody = '0;
  endtask

  task automatic drive();
    busIf.enable_i             = en;
    busIf.stall_i              = st;
    busIf.instFormat_i         = fmt;
    busIf.instructionOpcode_i  = 6'(opc);
    busIf.instruction_i        = {6'(opc), 5'(bo), 5'(bi), 14'(bd), 1'(aa), 1'(lk)};
    busIf.instructionAddress_i = addr;
    busIf.is64Bit_i            = m64;
    busIf.instructionPid_i     = pid;
    busIf.instructionTid_i     = tid;
    busIf.instructionMajId_i   = maj;
  endtask

  // One clock: predict from the branch rules, clock, then compare just after the edge.
  task automatic cycle(input string tag);
    drive();
    if (!st) begin
      if (en && fmt == 26'd2 && opc == 16) begin
        eEn   = 1'b1;
        eOp   = 64'(16 * 64 + aa * 2 + lk);
        eBody = 64'(bo * (2 ** 23) + bi * (2 ** 18) + bd * 16 + aa * 8 + lk * 4);
        eAddr = addr; eFu = 64'd6; eMaj = maj; eMin = 64'd0;
        e64   = 64'(m64); ePid = 64'(pid); eTid = 64'(tid);
      end else begin
        eEn = 1'b0;
      end
    end
    @(posedge clock_i);
    #1;
    checkAll(tag);
  endtask

  task automatic setRandom(input int opcode);
    en = 1'b1; st = 1'b0; fmt = 26'd2; opc = opcode;
    bo = int'($urandom_range(0, 31)); bi = int'($urandom_range(0, 31));
    bd = int'($urandom_range(0, 16383));
    aa = int'($urandom_range(0, 1)); lk = int'($urandom_range(0, 1));
    addr = {$urandom, $urandom}; maj = {$urandom, $urandom};
    pid = 20'($urandom); tid = 16'($urandom); m64 = 1'($urandom);
  endtask

  initial begin
    en = 1'b0; st = 1'b0; fmt = 26'd0; opc = 0; bo = 0; bi = 0; bd = 0; aa = 0; lk = 0;
    addr = '0; maj = '0; pid = '0; tid = '0; m64 = 1'b0;
    drive();
    modelReset();

    // reset with no clock edge yet
    #1 reset_i = 1'b1;
    #2 checkAll("reset_async");
    @(negedge clock_i);
    @(negedge clock_i);
    reset_i = 1'b0;

    // bca
    setRandom(16);
    bo = 14; bi = 17; bd = 1020; aa = 1; lk = 0; maj = 64'd16;
    cycle("bca");
    chk("bca.opcode_literal", 64'(busIf.opcode_o), 64'h402);
    chk("bca.fu_literal", 64'(busIf.functionalUnitType_o), 64'd6);
    chk("bca.body_literal", 64'(busIf.instructionBody_o),
        64'({5'b01110, 5'b10001, 14'b00001111111100, 1'b1, 1'b0, 2'b00}));

    // bcl then idle
    aa = 0; lk = 1;
    cycle("bcl");
    chk("bcl.opcode_literal", 64'(busIf.opcode_o), 64'h401);
    en = 1'b0;
    cycle("bcl_idle");

    // plain bc and bcla
    setRandom(16); aa = 0; lk = 0;
    cycle("bc");
    chk("bc.opcode_literal", 64'(busIf.opcode_o), 64'h400);
    setRandom(16); aa = 1; lk = 1;
    cycle("bcla");
    chk("bcla.opcode_literal", 64'(busIf.opcode_o), 64'h403);
    setRandom(16); aa = 0; lk = 0;
    cycle("bc_last");

    // opcode sweep: nothing but opcode 16 may be accepted
    for (int o = 0; o < 63; o++) begin
      if (o != 16) begin
        setRandom(o);
        cycle("sweep");
        en = 1'b0;
        cycle("sweep_idle");
      end
    end

    // wrong formats
    setRandom(16); fmt = 26'd4;
    cycle("fmt4");
    setRandom(16); fmt = 26'd3;
    cycle("fmt3");
    for (int k = 0; k < 8; k++) begin
      setRandom(16);
      fmt = 26'd1 << $urandom_range(2, 25);
      cycle("fmt_rand");
    end

    // stall: first bc frozen, second only appears when re-presented
    setRandom(16);
    cycle("stall_first");
    setRandom(16); st = 1'b1;
    for (int k = 0; k < 3; k++) cycle("stall_hold");
    chk("stall.enable_held", 64'(busIf.enable_o), 64'd1);
    st = 1'b0; en = 1'b0;
    cycle("stall_release_idle");
    en = 1'b1;
    cycle("stall_represent");

    // randomized traffic
    for (int k = 0; k < 300; k++) begin
      setRandom(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : 16);
      en = ($urandom_range(0, 3) != 0);
      st = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) fmt = 26'd1 << $urandom_range(0, 25);
      cycle("random");
    end

    // reset asserted mid-stall while enable_o is high
    setRandom(16);
    cycle("pre_reset");
    st = 1'b1;
    cycle("pre_reset_stall");
    #2 reset_i = 1'b1;
    #1 modelReset();
    checkAll("reset_mid_stall");
    @(negedge clock_i);
    reset_i = 1'b0;
    setRandom(16);
    cycle("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/b_format_decoder.md
# b_format_decoder

Format-specific decode stage for PowerPC B-form (conditional branch) instructions. It takes one fetched instruction per cycle from the decode front end and recognises primary opcode 16 (`bc`/`bca`/`bcl`/`bcla`). For a recognised instruction it emits a registered micro-op bundle (decoded opcode, branch functional-unit code, operand body, IDs) toward the dispatch/issue stage.

## Interface
Parameters:
- addressWidth, 64, instruction address width
- instructionWidth, 32, instruction word width
- PidSize, 20, process ID width
- TidSize, 16, thread ID width
- instructionCounterWidth, 64, major ID width
- instMinIdWidth, 7, minor ID width
- opcodeSize, 12, decoded opcode width
- PrimOpcodeSize, 6, primary opcode width
- regSize, 5, register/BO/BI field width
- immediateSize, 14, BD field width
- funcUnitCodeSize, 3, functional-unit code width
- BranchUnitID, 6, functional-unit code for the branch unit
- B, 2 (2**1), format one-hot value for B-form
- BDecoderInstance, 0, instance number, used only in debug messages

Ports (all vectors MSB-first, `[0:N-1]`):
- clock_i  in  1  clock; all state is rising-edge
- reset_i  in  1  asynchronous, active-high reset
- enable_i  in  1  input instruction valid
- stall_i  in  1  downstream stall; freezes this stage
- instFormat_i  in  26  one-hot format vector
- instructionOpcode_i  in  6  primary opcode
- instruction_i  in  32  raw instruction word
- instructionAddress_i  in  64  instruction address
- is64Bit_i  in  1  64-bit mode flag
- instructionPid_i  in  20  process ID
- instructionTid_i  in  16  thread ID
- instructionMajId_i  in  64  major ID
- enable_o  out  1  output bundle valid
- opcode_o  out  12  decoded opcode
- instructionAddress_o  out  64  address passthrough
- functionalUnitType_o  out  3  functional-unit code
- instMajId_o  out  64  major ID passthrough
- instMinId_o  out  7  minor ID
- is64Bit_o  out  1  mode passthrough
- instPid_o  out  20  PID passthrough
- instTid_o  out  16  TID passthrough
- instructionBody_o  out  28  operand body

## Operation
- Instruction fields: [0:5] opcode, [6:10] BO, [11:15] BI, [16:29] BD, [30] AA, [31] LK.
- Accept condition: enable_i=1, stall_i=0, instFormat_i equals B (the bit of weight 2^1 set), and instructionOpcode_i == 16.
- On accept, at the next rising edge:
  - enable_o=1.
  - opcode_o = {6'd16, 4'b0000, AA, LK}:
    - bc = 12'h400
    - bcl = 12'h401
    - bca = 12'h402
    - bcla = 12'h403
  - functionalUnitType_o = BranchUnitID.
  - instMinId_o = 0.
  - instructionBody_o = {BO, BI, BD, AA, LK, 2'b00}.
  - Address, is64Bit, PID, TID and major ID are copied unchanged from the inputs.
- enable_i=1 with stall_i=0 but the accept condition false (other opcode or format): next edge enable_o=0; other outputs hold their previous values.
- enable_i=0 with stall_i=0: next edge enable_o=0; other outputs hold.
- stall_i=1: all outputs, including enable_o, hold their current values and the input is dropped; the upstream stage must re-present it.

## Timing
- Latency is 1 cycle from an accepted input to enable_o=1. enable_o is a single-cycle pulse per accepted instruction unless stall_i holds it.
- Throughput is one instruction per cycle.
- Reset is asynchronous and takes precedence over everything. While reset_i=1, all outputs are 0, including enable_o, opcode_o, functionalUnitType_o, instructionBody_o and all IDs.
- The first edge after reset deasserts behaves as a normal cycle.
- reset_i asserted mid-stall or mid-pulse clears the outputs immediately.

## Configuration
- BFORMAT_DEBUG_EN defined:
  - On every accepted instruction, simulation-only `$display` prints instance number, major ID, address, BO, BI, BD, AA and LK.
  - On every enabled B-format input whose opcode is not 16, it prints a warning with the offending opcode.
- BFORMAT_DEBUG_EN undefined: no display statements; RTL behaviour is identical.

## Test plan
- Reset: pulse reset_i=1 with no clock edge -> all outputs immediately 0.
- bca: opcode 16, BO=01110, BI=10001, BD=14'b00001111111100, AA=1, LK=0, format=B, MajId=16 -> next cycle enable_o=1, opcode_o=12'h402, functionalUnitType_o=6, instructionBody_o={01110,10001,BD,1,0,00}, instMajId_o=16, instMinId_o=0.
- bcl: same fields with AA=0, LK=1 -> opcode_o=12'h401. The cycle after, with enable_i=0 -> enable_o=0.
- Opcode sweep 0..62 (excluding 16) with format=B, enable pulsed each time -> enable_o never 1; outputs retain the last bc values.
- Wrong format: opcode 16 with instFormat_i=4 -> enable_o=0.
- Stall: accept a bc, then hold stall_i=1 for 3 cycles while presenting another bc -> outputs frozen on the first instruction with enable_o=1; after release the second instruction appears only if re-presented.
